// File: rtl/uart_tx_frame.sv
// UART transmitter with a built-in baud divider, 1/2 stop bits, optional parity and a valid/ready intake.
// A frame's settings are captured at accept and stay fixed until the frame has left the pin.
module uart_tx_frame #(
    parameter int DATA_WIDTH = 8,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    output logic                  Ready,
    input  logic [DIV_WIDTH-1:0]  Baud_Div,
    input  logic                  parity_enable,
    input  logic                  parity_type,
    input  logic                  stop_bits,
    output logic                  TX_OUT,
    output logic                  busy,
    output logic [2:0]            state_dbg
);

    // Handshake: a frame is accepted on a rising CLK edge where Data_Valid
    // and Ready are both 1; Ready is 1 only in IDLE, so requests made while a
    // frame is in flight are dropped, never queued.

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    localparam int              CW       = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0]   LAST_BIT = CW'(DATA_WIDTH - 1);

    logic [2:0]            state;
    logic [DATA_WIDTH-1:0] shift_q;
    logic                  par_q;
    logic                  pe_q;
    logic                  sb_q;
    logic [DIV_WIDTH-1:0]  div_q;
    logic [DIV_WIDTH-1:0]  div_cnt;
    logic [CW-1:0]         bit_cnt;
    logic                  stop_cnt;
    logic                  tx_q;
    logic                  tick;

    assign tick = (div_cnt == div_q);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state    <= IDLE;
            shift_q  <= '0;
            par_q    <= 1'b0;
            pe_q     <= 1'b0;
            sb_q     <= 1'b0;
            div_q    <= '0;
            div_cnt  <= '0;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            tx_q     <= 1'b1;
        end else if (state == IDLE) begin
            if (Data_Valid) begin
                shift_q  <= P_DATA;
                // Parity is fixed at accept so later P_DATA changes cannot leak in.
                par_q    <= (^P_DATA) ^ parity_type;
                pe_q     <= parity_enable;
                sb_q     <= stop_bits;
                div_q    <= Baud_Div;
                div_cnt  <= '0;
                bit_cnt  <= '0;
                stop_cnt <= 1'b0;
                tx_q     <= 1'b0;
                state    <= START;
            end
        end else if (!tick) begin
            div_cnt <= div_cnt + 1'b1;
        end else begin
            div_cnt <= '0;
            case (state)
                START: begin
                    state <= DATA;
                    tx_q  <= shift_q[0];
                end
                DATA: begin
                    if (bit_cnt == LAST_BIT) begin
                        if (pe_q) begin
                            state <= PARITY;
                            tx_q  <= par_q;
                        end else begin
                            state <= STOP;
                            tx_q  <= 1'b1;
                        end
                    end else begin
                        // Next data bit is already sitting at shift_q[1].
                        bit_cnt <= bit_cnt + 1'b1;
                        shift_q <= shift_q >> 1;
                        tx_q    <= shift_q[1];
                    end
                end
                PARITY: begin
                    state <= STOP;
                    tx_q  <= 1'b1;
                end
                STOP: begin
                    if (sb_q && !stop_cnt) begin
                        stop_cnt <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    tx_q  <= 1'b1;
                end
            endcase
        end
    end

    assign Ready     = (state == IDLE);
    assign busy      = (state != IDLE);
    assign TX_OUT    = tx_q;
    assign state_dbg = state;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: an 8-bit and a 5-bit instance checked cycle by cycle
// against a frame-level waveform model ({busy, line} per clock).
module tb_uart_tx_frame;

    logic        CLK;
    logic        RST;

    logic [7:0]  d8;
    logic        dv8, pe8, pt8, sb8;
    logic [15:0] div8;
    logic        rdy8, tx8, busy8;
    logic [2:0]  st8;

    logic [4:0]  d5;
    logic        dv5, pe5, pt5, sb5;
    logic [15:0] div5;
    logic        rdy5, tx5, busy5;
    logic [2:0]  st5;

    int vectors;
    int miscompares;

    logic [1:0] exp_q[$];

    uart_tx_frame #(.DATA_WIDTH(8), .DIV_WIDTH(16)) dut8 (
        .CLK(CLK), .RST(RST), .P_DATA(d8), .Data_Valid(dv8), .Ready(rdy8),
        .Baud_Div(div8), .parity_enable(pe8), .parity_type(pt8), .stop_bits(sb8),
        .TX_OUT(tx8), .busy(busy8), .state_dbg(st8)
    );

    uart_tx_frame #(.DATA_WIDTH(5), .DIV_WIDTH(16)) dut5 (
        .CLK(CLK), .RST(RST), .P_DATA(d5), .Data_Valid(dv5), .Ready(rdy5),
        .Baud_Div(div5), .parity_enable(pe5), .parity_type(pt5), .stop_bits(sb5),
        .TX_OUT(tx5), .busy(busy5), .state_dbg(st5)
    );

    // clock / reset
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic logic [2:0] obs(input int w);
        return (w == 5) ? {rdy5, busy5, tx5} : {rdy8, busy8, tx8};
    endfunction

    // driver
    task automatic drive(input int w, input logic [8:0] data, input logic [15:0] div,
                         input bit pe, input bit pt, input bit sb, input bit dv);
        if (w == 5) begin
            d5 = data[4:0]; div5 = div; pe5 = pe; pt5 = pt; sb5 = sb; dv5 = dv;
        end else begin
            d8 = data[7:0]; div8 = div; pe8 = pe; pt8 = pt; sb8 = sb; dv8 = dv;
        end
    endtask

    // reference model: line levels of a whole frame, each stretched to div+1 clocks
    task automatic build_frame(input int w, input logic [8:0] data, input int div,
                               input bit pe, input bit pt, input bit sb);
        bit levels[$];
        int ones;
        ones = 0;
        levels.push_back(1'b0);
        for (int i = 0; i < w; i++) begin
            levels.push_back(data[i]);
            ones += int'(data[i]);
        end
        if (pe) levels.push_back(bit'((ones % 2) ^ int'(pt)));
        levels.push_back(1'b1);
        if (sb) levels.push_back(1'b1);
        foreach (levels[k])
            for (int c = 0; c <= div; c++) exp_q.push_back({1'b1, levels[k]});
    endtask

    // scoreboard: pop one {busy,line} per clock, sampled on the falling edge
    // mode 1: at cycle `at`, scramble dut8 config; mode 2: at cycle `at`, drop dut8 Data_Valid
    task automatic run_expected(input int w, input string tag, input int at, input int mode);
        int n;
        logic [1:0] e;
        logic [2:0] o;
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            if (i == at && mode == 1) begin
                div8 = 16'd0; pe8 = 1'b1; d8 = 8'hFF;
            end
            if (i == at && mode == 2) dv8 = 1'b0;
            e = exp_q.pop_front();
            o = obs(w);
            check({tag, "_line"},  {31'd0, o[0]}, {31'd0, e[0]});
            check({tag, "_busy"},  {31'd0, o[1]}, {31'd0, e[1]});
            check({tag, "_ready"}, {31'd0, o[2]}, {31'd0, ~e[1]});
            @(negedge CLK);
        end
    endtask

    // Called on a falling edge; returns on a falling edge one idle cycle after the frame.
    task automatic send(input int w, input string tag, input logic [8:0] data, input int div,
                        input bit pe, input bit pt, input bit sb, input int at, input int mode);
        logic [2:0] o;
        o = obs(w);
        check({tag, "_pre_ready"}, {31'd0, o[2]}, 32'd1);
        drive(w, data, 16'(div), pe, pt, sb, 1'b1);
        @(posedge CLK);
        #1;
        if (w == 5) dv5 = 1'b0; else dv8 = 1'b0;
        build_frame(w, data, div, pe, pt, sb);
        exp_q.push_back(2'b01);
        @(negedge CLK);
        run_expected(w, tag, at, mode);
    endtask

    initial begin
        logic [2:0] o;
        vectors = 0;
        miscompares = 0;
        RST = 1'b0;
        drive(8, 9'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(5, 9'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge CLK);
        check("rst_tx8",   {31'd0, tx8},   32'd1);
        check("rst_busy8", {31'd0, busy8}, 32'd0);
        check("rst_rdy8",  {31'd0, rdy8},  32'd1);
        check("rst_tx5",   {31'd0, tx5},   32'd1);
        check("rst_busy5", {31'd0, busy5}, 32'd0);
        RST = 1'b1;
        repeat (2) @(negedge CLK);

        // directed frames
        send(8, "basic_a5",   9'h0A5, 3, 1'b0, 1'b0, 1'b0, -1, 0);
        send(8, "even_sb2",   9'h0A5, 3, 1'b1, 1'b0, 1'b1, -1, 0);
        send(8, "odd_sb2",    9'h0A5, 3, 1'b1, 1'b1, 1'b1, -1, 0);
        send(8, "even_01",    9'h001, 3, 1'b1, 1'b0, 1'b1, -1, 0);
        send(8, "frozen_3c",  9'h03C, 3, 1'b0, 1'b0, 1'b0, 9, 1);
        send(8, "after_frz",  9'h0FF, 0, 1'b1, 1'b0, 1'b0, -1, 0);
        send(5, "w5_odd",     9'h016, 1, 1'b1, 1'b1, 1'b0, -1, 0);

        // back-to-back with Data_Valid held high
        drive(8, 9'h055, 16'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        @(posedge CLK);
        #1 d8 = 8'hAA;
        build_frame(8, 9'h055, 0, 1'b0, 1'b0, 1'b0);
        exp_q.push_back(2'b01);
        build_frame(8, 9'h0AA, 0, 1'b0, 1'b0, 1'b0);
        exp_q.push_back(2'b01);
        exp_q.push_back(2'b01);
        @(negedge CLK);
        run_expected(8, "b2b", 11, 2);

        // reset in the middle of data bit 3
        drive(8, 9'h00F, 16'd3, 1'b0, 1'b0, 1'b0, 1'b1);
        @(posedge CLK);
        #1 dv8 = 1'b0;
        repeat (18) @(negedge CLK);
        check("mid_busy", {31'd0, busy8}, 32'd1);
        #2 RST = 1'b0;
        #1;
        o = obs(8);
        check("arst_tx",   {31'd0, o[0]}, 32'd1);
        check("arst_busy", {31'd0, o[1]}, 32'd0);
        check("arst_rdy",  {31'd0, o[2]}, 32'd1);
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        send(8, "post_rst", 9'h00F, 3, 1'b0, 1'b0, 1'b0, -1, 0);

        // randomized frames on both widths
        for (int t = 0; t < 30; t++) begin
            int w;
            w = ($urandom_range(0, 2) == 0) ? 5 : 8;
            send(w, "rand", 9'($urandom_range(0, 511)), int'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), -1, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
